// File: rtl/loctag_pkg.sv
// loctag_pkg: shared ADC frame constants, frame-state type and helpers for the loctag front end
package loctag_pkg;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;
    localparam int ADC_W          = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} adc_state_t;

    function automatic logic [ADC_W-1:0] max_u(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/adc_trig_detect_if.sv
// adc_trig_detect_if: serial RSS ADC bus (chip select, serial clock, serial data)
interface adc_trig_detect_if;
    logic adc_cs;
    logic adc_clk;
    logic adc_so;

    modport master(output adc_cs, output adc_clk, input adc_so);
    modport slave(input adc_cs, input adc_clk, output adc_so);
endinterface

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: paces ADC frames at a fixed rate and deserialises each 16-bit frame into a 12-bit sample
module adc_spi_rx
    import loctag_pkg::*;
#(
    parameter int CLK_DIV       = 1,
    parameter int SAMPLE_PERIOD = 50
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    adc_trig_detect_if.master  adc,
    output logic [ADC_W-1:0]   sample,
    output logic               sample_valid
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(CLK_DIV + 1);

    adc_state_t       state, state_nx;
    logic [PW-1:0]    pcnt;
    logic [DW-1:0]    dcnt;
    logic [4:0]       bcnt;
    logic [ADC_W-1:0] shift;
    logic             start, tick, rise, last;

    assign start = en && pcnt == '0 && state == IDLE;
    assign tick  = dcnt == DW'(CLK_DIV - 1);
    assign rise  = state == CONV && tick && !adc.adc_clk;
    assign last  = rise && bcnt == 5'(ADC_FRAME_BITS - 1);

    // frame engine next state: IDLE -> CONV on frame start, CONV -> DONE after 16th rising edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CONV : IDLE;
            CONV:    state_nx = last ? DONE : CONV;
            default: state_nx = IDLE;
        endcase
    end

    // frame engine state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // period counter free-runs while enabled and parks at 0 otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pcnt <= '0;
        else if (!en)  pcnt <= '0;
        else           pcnt <= pcnt == PW'(SAMPLE_PERIOD - 1) ? '0 : pcnt + 1'b1;
    end

    // serial clock generation, bit capture on adc_clk rising edges and sample hand-off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc.adc_cs   <= 1'b1;
            adc.adc_clk  <= 1'b1;
            dcnt         <= '0;
            bcnt         <= '0;
            shift        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            adc.adc_cs   <= state_nx == IDLE;
            sample_valid <= state == DONE;
            if (state == DONE) sample <= shift;
            if (start) begin
                dcnt <= '0;
                bcnt <= '0;
            end else if (state == CONV) begin
                dcnt <= tick ? '0 : dcnt + 1'b1;
                if (tick) adc.adc_clk <= ~adc.adc_clk;
                if (rise) begin
                    shift <= {shift[ADC_W-2:0], adc.adc_so};
                    bcnt  <= bcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/adc_trig_detect.sv
// adc_trig_detect: ADC front end with hysteresis/debounce packet-present detection and peak RSS hold
module adc_trig_detect
    import loctag_pkg::*;
#(
    parameter int               CLK_DIV       = 1,
    parameter int               SAMPLE_PERIOD = 50,
    parameter logic [ADC_W-1:0] TH_HI         = 12'd1200,
    parameter logic [ADC_W-1:0] TH_LO         = 12'd1000,
    parameter int               ON_COUNT      = 3,
    parameter int               OFF_COUNT     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    adc_trig_detect_if.master  adc,
    output logic [ADC_W-1:0]   sample,
    output logic               sample_valid,
    output logic               trig,
    output logic               trig_rise,
    output logic [ADC_W-1:0]   rss
);
    localparam int CW = $clog2((ON_COUNT > OFF_COUNT ? ON_COUNT : OFF_COUNT) + 1);

    logic [CW-1:0] on_cnt, off_cnt, on_inc, off_inc;
    logic          hi, lo;

    assign hi      = sample >= TH_HI;
    assign lo      = sample < TH_LO;
    assign on_inc  = on_cnt == '1 ? on_cnt : on_cnt + 1'b1;
    assign off_inc = off_cnt == '1 ? off_cnt : off_cnt + 1'b1;

    adc_spi_rx #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .adc         (adc),
        .sample      (sample),
        .sample_valid(sample_valid)
    );

    // debounced trig with separate on/off thresholds; rss tracks the packet peak and holds after it ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig      <= 1'b0;
            trig_rise <= 1'b0;
            rss       <= '0;
            on_cnt    <= '0;
            off_cnt   <= '0;
        end else if (!en) begin
            trig      <= 1'b0;
            trig_rise <= 1'b0;
            on_cnt    <= '0;
            off_cnt   <= '0;
        end else begin
            trig_rise <= 1'b0;
            if (sample_valid && !trig) begin
                on_cnt <= hi ? on_inc : '0;
                if (hi && on_inc == CW'(ON_COUNT)) begin
                    trig      <= 1'b1;
                    trig_rise <= 1'b1;
                    rss       <= sample;
                    on_cnt    <= '0;
                end
            end else if (sample_valid) begin
                off_cnt <= lo ? off_inc : '0;
                rss     <= max_u(rss, sample);
                if (lo && off_inc == CW'(OFF_COUNT)) begin
                    trig    <= 1'b0;
                    off_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_trig_detect.sv
// tb_adc_trig_detect: serial ADC model feeding a scoreboard of expected samples, trig and rss
module tb_adc_trig_detect;
    import loctag_pkg::*;

    localparam int PER = 20;

    typedef struct {
        logic [11:0] s;
        logic        trig;
        logic        rise;
        logic [11:0] rss;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [11:0] sample, rss;
    logic        sample_valid, trig, trig_rise;

    adc_trig_detect_if adc();

    adc_trig_detect dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .adc         (adc),
        .sample      (sample),
        .sample_valid(sample_valid),
        .trig        (trig),
        .trig_rise   (trig_rise),
        .rss         (rss)
    );

    always #(PER/2) clk = ~clk;

    exp_t        sb[$];
    logic [11:0] vals[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        exp_en = 1'b1;
    logic        m_trig = 1'b0;
    int          m_on = 0;
    int          m_off = 0;
    logic [11:0] m_rss = '0;
    logic [15:0] word = '0;
    int          bidx = -1;
    time         t_cs = 0;
    time         t_csr = 0;
    bit          csr_seen = 1'b0;
    time         t0;
    int          lows;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    task automatic predict(input logic [11:0] s);
        exp_t e;
        e.s    = s;
        e.rise = 1'b0;
        if (!exp_en) begin
            m_trig = 1'b0;
            m_on   = 0;
            m_off  = 0;
        end else if (!m_trig) begin
            m_on = s >= 12'd1200 ? m_on + 1 : 0;
            if (m_on == 3) begin
                m_trig = 1'b1;
                e.rise = 1'b1;
                m_rss  = s;
                m_on   = 0;
            end
        end else begin
            m_off = s < 12'd1000 ? m_off + 1 : 0;
            if (s > m_rss) m_rss = s;
            if (m_off == 8) begin
                m_trig = 1'b0;
                m_off  = 0;
            end
        end
        e.trig = m_trig;
        e.rss  = m_rss;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((vals.size() != 0 || sb.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", n < 4000, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic load(input logic [11:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) vals.push_back(v);
    endtask

    // ADC model: a frame starts on cs falling, one bit presented per adc_clk falling edge
    always @(negedge adc.adc_cs) begin
        logic [11:0] v;
        if (csr_seen) check("cs_gap", ($time - t_csr) >= 2*PER, 1);
        t_cs = $time;
        v = 12'h000;
        if (vals.size() != 0) v = vals.pop_front();
        word = {4'h0, v};
        bidx = 15;
        predict(v);
    end

    always @(posedge adc.adc_cs) begin
        t_csr    = $time;
        csr_seen = 1'b1;
    end

    always @(negedge adc.adc_clk) begin
        if (bidx >= 0) begin
            adc.adc_so = word[bidx];
            bidx--;
        end
    end

    // output monitor: compare each sample, then trig/rise/rss one cycle later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sample_valid === 1'b1) begin
                if (sb.size() == 0) check("sb_empty", 0, 1);
                else begin
                    e = sb.pop_front();
                    check("sample", sample, e.s);
                    check("valid_lat", ($time - 1 - t_cs) / PER, 33);
                    @(posedge clk);
                    #1;
                    if (reset_n) begin
                        check("trig", trig, e.trig);
                        check("trig_rise", trig_rise, e.rise);
                        check("rss", rss, e.rss);
                    end
                end
            end
        end
    end

    initial begin
        #(PER*60000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        en         = 1'b0;
        adc.adc_so = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", adc.adc_cs, 1);
        check("rst_sclk", adc.adc_clk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_trig", trig, 0);
        check("rst_rise", trig_rise, 0);
        check("rst_rss", rss, 0);

        load(12'hABC, 2);
        en = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_frame_cs", adc.adc_cs, 0);
        t0 = $time - 1;
        @(negedge adc.adc_cs);
        check("frame_period", ($time - t0) / PER, 50);
        drain();

        load(12'd1300, 3);
        load(12'd1500, 1);
        load(12'd1100, 1);
        load(12'd900, 7);
        load(12'd1100, 1);
        load(12'd900, 8);
        drain();
        check("trig_fell", trig, 0);
        check("rss_hold", rss, 1500);

        load(12'd1300, 2);
        load(12'd900, 1);
        load(12'd1300, 1);
        drain();
        check("no_trig", trig, 0);

        load(12'd1300, 3);
        drain();
        check("trig_on", trig, 1);

        @(negedge adc.adc_cs);
        repeat (15) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_cs", adc.adc_cs, 1);
        check("mid_rst_sclk", adc.adc_clk, 1);
        check("mid_rst_trig", trig, 0);
        check("mid_rst_rss", rss, 0);
        sb.delete();
        m_trig = 1'b0;
        m_on   = 0;
        m_off  = 0;
        m_rss  = '0;
        vals.push_back(12'h5A5);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_cs", adc.adc_cs, 0);
        drain();

        load(12'd1300, 3);
        drain();
        vals.push_back(12'd1400);
        exp_en = 1'b0;
        @(negedge adc.adc_cs);
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        drain();
        lows = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (adc.adc_cs !== 1'b1) lows++;
        end
        check("no_new_frame", lows, 0);
        check("en_off_trig", trig, 0);
        check("en_off_sample", sample, 1400);
        check("en_off_rss", rss, 1300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_trig_detect.md
# adc_trig_detect

Front-end stage feeding the `loctag` MAC/timing FSM. Drives the serial 12-bit RSS ADC (16-clock frame, 4 leading zeros, MSB first) at a fixed sample rate, delivers each conversion as a parallel sample, and derives the `trig` level (packet-present) with threshold hysteresis and debounce. It also reports a peak-hold RSS value for the current packet.

## Interface
Parameters:
- `CLK_DIV`, 1: `adc_clk` half-period in `clk` cycles (1 → 25 MHz at 50 MHz `clk`).
- `SAMPLE_PERIOD`, 50: `clk` cycles between frame starts (1 MS/s). Must be ≥ 32*CLK_DIV+3.
- `TH_HI`, 12'd1200: trig-on threshold (sample ≥ TH_HI).
- `TH_LO`, 12'd1000: trig-off threshold (sample < TH_LO). Must be ≤ TH_HI.
- `ON_COUNT`, 3: consecutive samples ≥ TH_HI needed to assert trig.
- `OFF_COUNT`, 8: consecutive samples < TH_LO needed to deassert trig.

Ports:
- `clk` in 1: 50 MHz system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: sampling enable.
- `adc_cs` out 1: ADC chip select, active low.
- `adc_clk` out 1: ADC serial clock, idles high.
- `adc_so` in 1: ADC serial data.
- `sample` out 12: last conversion result.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `trig` out 1: packet-present level, feeds `loctag.trig`.
- `trig_rise` out 1: one-cycle pulse on trig 0→1.
- `rss` out 12: peak sample of the current/last packet.

## Operation
- Reset values: adc_cs=1, adc_clk=1, sample=0, sample_valid=0, trig=0, trig_rise=0, rss=0. Period, bit and debounce counters are also 0.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps while en=1. A frame starts when the count is 0 and the engine is IDLE. With en=0 the counter holds at 0.
- Frame engine states:
  - IDLE: cs high, clk high. Leaves for CONV on a frame start.
  - CONV: cs low, adc_clk toggles every CLK_DIV cycles, 16 rising edges. On each rising edge, adc_so is shifted into a 16-bit register, MSB first.
  - DONE: one cycle. cs high, load `sample` = shift[11:0], pulse `sample_valid`, return to IDLE.
- Leading-zero bits shift[15:12] are discarded without checking.
- en falling mid-frame: the current frame completes and produces its sample. No new frame starts.
- Detector, evaluated on each sample_valid:
  - trig=0: if sample ≥ TH_HI, increment on_cnt, else clear it. When on_cnt reaches ON_COUNT, set trig=1, pulse trig_rise, set rss=sample, clear on_cnt.
  - trig=1: if sample < TH_LO, increment off_cnt, else clear it. rss = max(rss, sample). When off_cnt reaches OFF_COUNT, set trig=0 and clear off_cnt.
  - Samples in [TH_LO, TH_HI) clear on_cnt when trig=0 and clear off_cnt when trig=1.
  - rss holds after trig falls until the next rise.
- en=0 clears trig, on_cnt and off_cnt synchronously. rss and sample hold.
- Comparisons are unsigned 12-bit. Counters saturate, no wrap.

## Timing
- Cycle 0 = frame start. adc_cs falls at cycle 0.
- adc_clk falls at CLK_DIV and rises at 2k*CLK_DIV, k=1..16.
- adc_so is captured on the clk edge that drives adc_clk high, i.e. bit 15 at cycle 2*CLK_DIV.
- At cycle 32*CLK_DIV+1, adc_cs rises and sample/sample_valid update.
- trig and trig_rise update one cycle after sample_valid. Latency from frame start to trig is 32*CLK_DIV+2 cycles.
- adc_cs stays high for at least SAMPLE_PERIOD−32*CLK_DIV−1 ≥ 2 cycles between frames.
- reset_n low mid-frame: outputs go to reset values immediately, and the partial frame is discarded. The first frame starts on the first clk edge after reset_n rises with en=1.
- en rising: the first frame starts on the next cycle.

## Structure
- Shared package `loctag_pkg`:
  - `ADC_W`=12, `ADC_FRAME_BITS`=16, `ADC_LEAD_ZEROS`=4.
  - The frame-state enum {IDLE, CONV, DONE}.
- Sub-module `adc_spi_rx` contains the period counter and frame engine, and outputs sample/sample_valid.
- The detector and rss logic live in the top module `adc_trig_detect`.

## Test plan
- ADC model returns 0x0ABC with 4 leading zeros, CLK_DIV=1 → sample=0xABC with sample_valid at cycle 33. Frames repeat every 50 cycles. cs stays high ≥ 2 cycles between frames.
- Sample sequence 1300,1300,1300 → trig rises 1 cycle after the third valid, with trig_rise pulse and rss=1300. Then 1500, 1100 → rss=1500, trig stays 1.
- Sequence 1300,1300,900,1300 → no trig, because on_cnt clears on 900.
- With trig=1, seven 900s then 1100 then eight 900s → trig falls only after the eighth consecutive 900. rss holds 1500 after the fall.
- reset_n pulsed low at cycle 15 of a frame → cs=1, adc_clk=1, trig=0, rss=0 immediately. The next frame starts the first cycle after release and decodes correctly.
- en dropped at cycle 10 of a frame → that frame still yields sample_valid at cycle 33, no further frames start, and trig=0.
